// File: rtl/next_hop_select.sv
// Scans the best-neighbour table in memory and picks the next hop: fewest hops first,
// then highest Q, lowest index on a full tie. The chosen ID is written back to memory.
module next_hop_select (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic [10:0] address,
  output logic [15:0] data_out,
  output logic        wr_en,
  output logic [15:0] nexthopID,
  output logic [15:0] nexthopH,
  output logic [15:0] nexthopQ,
  output logic        no_route,
  output logic        done
);

  localparam logic [10:0] ADDR_COUNT = 11'h2B8;
  localparam logic [10:0] ADDR_OUT   = 11'h2BA;
  localparam logic [10:0] ADDR_ID    = 11'h2F8;
  localparam logic [10:0] ADDR_HOP   = 11'h308;
  localparam logic [10:0] ADDR_Q     = 11'h318;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_ID, S_HOP, S_Q, S_CMP, S_WRITE, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_i;
  logic [3:0]  r_n;
  logic [15:0] r_cand_id, r_cand_h, r_cand_q;
  logic        w_take, w_last;

  function automatic logic [3:0] sat_count(input logic [15:0] cnt);
    return (cnt > 16'd8) ? 4'd8 : cnt[3:0];
  endfunction

  function automatic logic [10:0] addr_at(input logic [10:0] base, input logic [2:0] idx);
    return base + {7'd0, idx, 1'b0};
  endfunction

  assign w_take = (r_i == 3'd0) || (r_cand_h < nexthopH) ||
                  ((r_cand_h == nexthopH) && (r_cand_q > nexthopQ));
  assign w_last = (({1'b0, r_i} + 4'd1) == r_n);

  always_ff @(posedge clock) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_COUNT;
        S_COUNT: w_next = (data_in == 16'd0) ? S_DONE : S_ID;
        S_ID:    w_next = S_HOP;
        S_HOP:   w_next = S_Q;
        S_Q:     w_next = S_CMP;
        S_CMP:   w_next = w_last ? S_WRITE : S_ID;
        S_WRITE: w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      address   <= '0;
      data_out  <= '0;
      wr_en     <= 1'b0;
      nexthopID <= '0;
      nexthopH  <= '0;
      nexthopQ  <= '0;
      no_route  <= 1'b0;
      done      <= 1'b0;
      r_i       <= '0;
      r_n       <= '0;
      r_cand_id <= '0;
      r_cand_h  <= '0;
      r_cand_q  <= '0;
    end else begin
      // Strobes default low; an en drop therefore also cancels a pending write.
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (en) begin
        case (r_state)
          S_IDLE: if (start) begin
            address  <= ADDR_COUNT;
            no_route <= 1'b0;
          end
          S_COUNT: begin
            r_n <= sat_count(data_in);
            if (data_in == 16'd0) begin
              no_route  <= 1'b1;
              nexthopID <= '0;
              nexthopH  <= '0;
              nexthopQ  <= '0;
            end else begin
              r_i     <= '0;
              address <= ADDR_ID;
            end
          end
          S_ID: begin
            r_cand_id <= data_in;
            address   <= addr_at(ADDR_HOP, r_i);
          end
          S_HOP: begin
            r_cand_h <= data_in;
            address  <= addr_at(ADDR_Q, r_i);
          end
          S_Q: r_cand_q <= data_in;
          S_CMP: begin
            if (w_take) begin
              nexthopID <= r_cand_id;
              nexthopH  <= r_cand_h;
              nexthopQ  <= r_cand_q;
            end
            if (w_last) begin
              address  <= ADDR_OUT;
              data_out <= w_take ? r_cand_id : nexthopID;
              wr_en    <= 1'b1;
            end else begin
              r_i     <= r_i + 3'd1;
              address <= addr_at(ADDR_ID, r_i + 3'd1);
            end
          end
          S_DONE:  done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/next_hop_select.md
NEXT_HOP_SELECT -- requirements
Module: next_hop_select

Interface
REQ-001 The block SHALL have these ports: clock, input, 1 bit, system clock (all logic on the rising edge).
REQ-002 The block SHALL have these ports: nrst, input, 1 bit, reset; synchronous, active-low.
REQ-003 en, input, 1 bit: block enable; low forces abort to S_IDLE.
REQ-004 start, input, 1 bit: begin selection; sampled only in S_IDLE.
REQ-005 data_in, input, 16 bits: memory read data; combinational read of mem[address] in the same cycle.
REQ-006 address, output, 11 bits: registered byte address; word stride 2.
REQ-007 data_out, output, 16 bits: registered write data.
REQ-008 wr_en, output, 1 bit: registered write strobe.
REQ-009 nexthopID, nexthopH and nexthopQ, outputs, 16 bits each: registered ID, hop count and Q value of the chosen neighbour.
REQ-010 no_route, output, 1 bit: registered flag; the best-neighbour list was empty.
REQ-011 done, output, 1 bit: registered one-cycle completion pulse.

Function
REQ-012 Memory map, 16-bit words:
- bestNeighborsCount at 0x2B8.
- bestNeighborID[i] at 0x2F8+2i.
- bestNeighborHops[i] at 0x308+2i.
- bestNeighborQ[i] at 0x318+2i.
- chosen next hop written to 0x2BA.
- i is 0..7.
REQ-013 States SHALL be S_IDLE, S_COUNT, S_ID, S_HOP, S_Q, S_CMP, S_WRITE and S_DONE, with a 3-bit index i and a 4-bit count N.
REQ-014 S_IDLE, en=1 and start=1: address<=0x2B8, clear no_route, go to S_COUNT; otherwise stay.
REQ-015 S_COUNT: N<=min(data_in,8), unsigned clamp.
- N=0: no_route<=1, nexthop outputs<=0, go to S_DONE with no write.
- Otherwise: i<=0, address<=0x2F8, go to S_ID.
REQ-016 S_ID: latch candidate ID; address<=0x308+2i; go to S_HOP.
REQ-017 S_HOP: latch candidate hops; address<=0x318+2i; go to S_Q.
REQ-018 S_Q: latch candidate Q; go to S_CMP.
REQ-019 S_CMP: candidate replaces the current best (nexthopID/H/Q) if any of the following holds:
- i=0; or
- candidate hops < best hops; or
- hops are equal and candidate Q > best Q.
- All comparisons are unsigned 16-bit.
- Ties on both hops and Q keep the lower index.
REQ-020 S_CMP, after the update: if i+1=N, address<=0x2BA, data_out<=chosen ID, wr_en<=1, go to S_WRITE; else i<=i+1, address<=0x2F8+2(i+1), go to S_ID.
REQ-021 S_WRITE: wr_en<=0; go to S_DONE; wr_en SHALL be high for exactly one cycle per selection.
REQ-022 S_DONE: done high for exactly this cycle; go to S_IDLE.
REQ-023 Latency, counted in cycles from the edge sampling start to the cycle where done=1:
- 4N+3 cycles for N≥1.
- 2 cycles for N=0.
REQ-024 nexthopID/H/Q and no_route SHALL hold their values in S_IDLE until the next accepted start.
REQ-025 start asserted outside S_IDLE SHALL be ignored.
REQ-026 en=0 in any state SHALL take the block to S_IDLE on the next edge, with:
- wr_en<=0, done<=0;
- no memory write;
- result outputs unchanged.
REQ-027 address SHALL change only in the transitions listed; it holds otherwise.

Reset
REQ-028 nrst=0 at an edge SHALL set, regardless of state (including mid-scan or in S_WRITE):
- state to S_IDLE;
- address, data_out, nexthopID, nexthopH, nexthopQ, i and N to 0;
- wr_en, done and no_route to 0.
REQ-029 A write in progress when reset hits SHALL be dropped.

Verification
REQ-030 Count=3, hops {3,2,2}, Q {10,5,9}, IDs {7,4,9}. Response:
- nexthopID=9, H=2, Q=9;
- one write of 9 to 0x2BA;
- done 15 cycles after start.
REQ-031 Count=0 -> no_route=1, nexthop outputs=0, no wr_en, done 2 cycles after start.
REQ-032 Count=12 -> exactly 8 entries read (last address 0x326); selection uses i=0..7 only.
REQ-033 Count=2, both entries hop=1 and Q=20, IDs {5,6} -> nexthopID=5.
REQ-034 Abort cases: en dropped in S_HOP of entry 1 -> S_IDLE next cycle, no write, no done. nrst pulsed in S_WRITE -> all outputs 0, no done.
REQ-035 start held high through a run -> a second run begins only after the S_DONE cycle; outputs persist between runs.
